// File: rtl/vu_peak_feed.sv
// vu_peak_feed
//   Feeder for the VU meter. Tracks the peak-magnitude sample of each
//   interleaved channel over DECIMATION samples. It emits one peak per
//   channel per block and also generates the periodic vm_sync strobe.
//
// Ports
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   s_signal_d    input sample, signed INPUT_WIDTH
//   s_signal_ch   input channel index
//   s_signal_dv   input sample valid
//   vm_signal_d   emitted peak sample (unmodified winning sample)
//   vm_signal_ch  channel of emitted peak
//   vm_signal_dv  single-cycle peak valid
//   vm_sync       single-cycle strobe every SYNC_DIVIDER clocks
module vu_peak_feed #(
    parameter int NR_CHANNELS  = 4,
    parameter int INPUT_WIDTH  = 24,
    parameter int DECIMATION   = 48,
    parameter int SYNC_DIVIDER = 1000000,
    localparam int CH_W   = (NR_CHANNELS > 1) ? $clog2(NR_CHANNELS) : 1,
    localparam int CNT_W  = (DECIMATION > 1) ? $clog2(DECIMATION) : 1,
    localparam int SYNC_W = $clog2(SYNC_DIVIDER)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [INPUT_WIDTH-1:0] s_signal_d,
    input  logic [CH_W-1:0]        s_signal_ch,
    input  logic                   s_signal_dv,
    output logic [INPUT_WIDTH-1:0] vm_signal_d,
    output logic [CH_W-1:0]        vm_signal_ch,
    output logic                   vm_signal_dv,
    output logic                   vm_sync
);

    // One's-complement magnitude: -1 maps to 0, matching the meter's level map.
    function automatic logic [INPUT_WIDTH-2:0] mag(input logic [INPUT_WIDTH-1:0] x);
        return x[INPUT_WIDTH-1] ? ~x[INPUT_WIDTH-2:0] : x[INPUT_WIDTH-2:0];
    endfunction

    localparam logic [CH_W:0]     NCH      = (CH_W+1)'(NR_CHANNELS);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DECIMATION - 1);
    localparam logic [SYNC_W-1:0] SYNC_LAST = SYNC_W'(SYNC_DIVIDER - 1);

    logic [INPUT_WIDTH-1:0] peak_q [NR_CHANNELS];
    logic [CNT_W-1:0]       cnt_q  [NR_CHANNELS];

    logic                   ch_ok, accept, last;
    logic [CH_W-1:0]        idx;
    logic [INPUT_WIDTH-1:0] cur_peak, win;
    logic [CNT_W-1:0]       cur_cnt;

    // Extended-width compare keeps the range check meaningful for every
    // NR_CHANNELS, including exact powers of two.
    always_comb begin
        ch_ok    = ({1'b0, s_signal_ch} < NCH);
        accept   = s_signal_dv & ch_ok;
        idx      = ch_ok ? s_signal_ch : '0;
        cur_peak = peak_q[idx];
        cur_cnt  = cnt_q[idx];
        // Strict compare: on a tie the stored sample is kept.
        win      = (mag(s_signal_d) > mag(cur_peak)) ? s_signal_d : cur_peak;
        last     = (cur_cnt == CNT_LAST);
    end

    // Per-channel peak and sample counters, written only by their own channel.
    for (genvar g = 0; g < NR_CHANNELS; g++) begin : g_ch
        always_ff @(posedge clk) begin
            if (rst) begin
                peak_q[g] <= '0;
                cnt_q[g]  <= '0;
            end else if (accept && idx == CH_W'(g)) begin
                if (last) begin
                    peak_q[g] <= '0;
                    cnt_q[g]  <= '0;
                end else begin
                    peak_q[g] <= win;
                    cnt_q[g]  <= cnt_q[g] + CNT_W'(1);
                end
            end
        end
    end

    // Output stage: data/channel hold their last value while dv is low.
    logic [INPUT_WIDTH-1:0] sig_d_q;
    logic [CH_W-1:0]        sig_ch_q;
    logic                   sig_dv_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_d_q  <= '0;
            sig_ch_q <= '0;
            sig_dv_q <= 1'b0;
        end else begin
            sig_dv_q <= accept & last;
            if (accept && last) begin
                sig_d_q  <= win;
                sig_ch_q <= idx;
            end
        end
    end

    // Free-running sync generator, independent of the sample path.
    logic [SYNC_W-1:0] sync_cnt_q, sync_cnt_d;
    logic              sync_q, sync_d;

    always_comb begin
        sync_cnt_d = sync_cnt_q + SYNC_W'(1);
        sync_d     = 1'b0;
        if (sync_cnt_q == SYNC_LAST) begin
            sync_cnt_d = '0;
            sync_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_cnt_q <= '0;
            sync_q     <= 1'b0;
        end else begin
            sync_cnt_q <= sync_cnt_d;
            sync_q     <= sync_d;
        end
    end

    assign vm_signal_d  = sig_d_q;
    assign vm_signal_ch = sig_ch_q;
    assign vm_signal_dv = sig_dv_q;
    assign vm_sync      = sync_q;

endmodule

// File: tb/tb_vu_peak_feed.sv
// Directed bench for vu_peak_feed.
//   dut1: 4 channels, DECIMATION=4, SYNC_DIVIDER=5 (peak, tie, interleave,
//         sync, reset mid-block)
//   dut2: 5 channels (3-bit channel field), DECIMATION=1 (pass-through,
//         out-of-range channel indices 5 and 7)
module tb_vu_peak_feed;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // dut1
    logic [23:0] s1_d  = '0;
    logic [1:0]  s1_ch = '0;
    logic        s1_dv = 1'b0;
    logic [23:0] o1_d;
    logic [1:0]  o1_ch;
    logic        o1_dv, o1_sync;

    // dut2
    logic [23:0] s2_d  = '0;
    logic [2:0]  s2_ch = '0;
    logic        s2_dv = 1'b0;
    logic [23:0] o2_d;
    logic [2:0]  o2_ch;
    logic        o2_dv, o2_sync;

    vu_peak_feed #(.NR_CHANNELS(4), .INPUT_WIDTH(24), .DECIMATION(4), .SYNC_DIVIDER(5)) dut1 (
        .clk(clk), .rst(rst),
        .s_signal_d(s1_d), .s_signal_ch(s1_ch), .s_signal_dv(s1_dv),
        .vm_signal_d(o1_d), .vm_signal_ch(o1_ch), .vm_signal_dv(o1_dv), .vm_sync(o1_sync)
    );

    vu_peak_feed #(.NR_CHANNELS(5), .INPUT_WIDTH(24), .DECIMATION(1), .SYNC_DIVIDER(5)) dut2 (
        .clk(clk), .rst(rst),
        .s_signal_d(s2_d), .s_signal_ch(s2_ch), .s_signal_dv(s2_dv),
        .vm_signal_d(o2_d), .vm_signal_ch(o2_ch), .vm_signal_dv(o2_dv), .vm_sync(o2_sync)
    );

    int n_run  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic [1:0] ch, input logic [23:0] d);
        s1_dv = 1'b1; s1_ch = ch; s1_d = d;
        tick();
        s1_dv = 1'b0;
    endtask

    task automatic send2(input logic [2:0] ch, input logic [23:0] d);
        s2_dv = 1'b1; s2_ch = ch; s2_d = d;
        tick();
        s2_dv = 1'b0;
    endtask

    // Interleave stimulus [round][channel] and the expected per-channel peaks
    logic [23:0] il [4][4];
    logic [23:0] il_exp [4];

    // Pass-through table: ch, d, expected dv/ch/d after the edge
    typedef struct {
        logic [2:0]  ch;
        logic [23:0] d;
        logic        edv;
        logic [2:0]  ech;
        logic [23:0] ed;
    } pt_t;
    pt_t pt [7];

    initial begin
        il[0] = '{24'h000010, 24'hFFFF00, 24'h000001, 24'h800000};
        il[1] = '{24'hFFFFFB, 24'h000050, 24'h000002, 24'h7FFFFF};
        il[2] = '{24'h000300, 24'h000007, 24'h000003, 24'h000000};
        il[3] = '{24'h000020, 24'h000001, 24'h7FFFFF, 24'h000000};
        il_exp = '{24'h000300, 24'hFFFF00, 24'h7FFFFF, 24'h800000};

        pt[0] = '{3'd0, 24'h123456, 1'b1, 3'd0, 24'h123456};
        pt[1] = '{3'd4, 24'h800000, 1'b1, 3'd4, 24'h800000};
        pt[2] = '{3'd2, 24'hFFFFFF, 1'b1, 3'd2, 24'h000000};  // -1: m=0, cleared peak wins
        pt[3] = '{3'd1, 24'h000000, 1'b1, 3'd1, 24'h000000};
        pt[4] = '{3'd3, 24'h7FFFFF, 1'b1, 3'd3, 24'h7FFFFF};
        pt[5] = '{3'd5, 24'h111111, 1'b0, 3'd3, 24'h7FFFFF};  // out of range: hold
        pt[6] = '{3'd7, 24'h222222, 1'b0, 3'd3, 24'h7FFFFF};

        // Reset state
        tick(); tick();
        chk("rst dv1",   32'(o1_dv),   0);
        chk("rst d1",    32'(o1_d),    0);
        chk("rst ch1",   32'(o1_ch),   0);
        chk("rst sync1", 32'(o1_sync), 0);
        chk("rst dv2",   32'(o2_dv),   0);
        chk("rst d2",    32'(o2_d),    0);

        // Sync: high in cycles 5, 10, 15 after release
        rst = 1'b0;
        for (int c = 1; c <= 16; c++) begin
            tick();
            chk($sformatf("sync c%0d", c), 32'(o1_sync), (c % 5 == 0) ? 1 : 0);
        end

        // Basic peak on ch0
        send1(2'd0, 24'h000100); chk("basic dv s1", 32'(o1_dv), 0);
        send1(2'd0, 24'hFFF000); chk("basic dv s2", 32'(o1_dv), 0);
        send1(2'd0, 24'h000800); chk("basic dv s3", 32'(o1_dv), 0);
        send1(2'd0, 24'h000010);
        chk("basic dv", 32'(o1_dv), 1);
        chk("basic ch", 32'(o1_ch), 0);
        chk("basic d",  32'(o1_d),  32'h00FFF000);
        tick();
        chk("basic dv drop", 32'(o1_dv), 0);
        chk("basic d hold",  32'(o1_d),  32'h00FFF000);

        // Tie keeps the stored sample
        send1(2'd1, 24'h000FFF);
        send1(2'd1, 24'hFFF000);
        send1(2'd1, 24'h000001);
        send1(2'd1, 24'h000002);
        chk("tie dv", 32'(o1_dv), 1);
        chk("tie ch", 32'(o1_ch), 1);
        chk("tie d",  32'(o1_d),  32'h00000FFF);
        tick();

        // Interleaved 4 channels x 4 rounds
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                send1(2'(c), il[r][c]);
                if (r == 3) begin
                    chk($sformatf("il dv ch%0d", c), 32'(o1_dv), 1);
                    chk($sformatf("il ch ch%0d", c), 32'(o1_ch), 32'(c));
                    chk($sformatf("il d ch%0d", c),  32'(o1_d),  32'(il_exp[c]));
                end else begin
                    chk($sformatf("il quiet r%0d c%0d", r, c), 32'(o1_dv), 0);
                end
            end
        end
        tick();
        chk("il dv drop", 32'(o1_dv), 0);

        // DECIMATION=1 pass-through, back-to-back, then out-of-range channels
        for (int i = 0; i < 7; i++) begin
            s2_dv = 1'b1; s2_ch = pt[i].ch; s2_d = pt[i].d;
            tick();
            chk($sformatf("pt%0d dv", i), 32'(o2_dv), 32'(pt[i].edv));
            chk($sformatf("pt%0d ch", i), 32'(o2_ch), 32'(pt[i].ech));
            chk($sformatf("pt%0d d", i),  32'(o2_d),  32'(pt[i].ed));
        end
        s2_dv = 1'b0;
        tick();
        chk("pt idle dv", 32'(o2_dv), 0);

        // Reset mid-block: 3 of 4 samples, then reset
        send1(2'd0, 24'h7FFFFF);
        send1(2'd0, 24'h400000);
        send1(2'd0, 24'h000100);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst d",    32'(o1_d),    0);
        chk("mrst sync", 32'(o1_sync), 0);
        send1(2'd0, 24'h000010); chk("mrst sync c1", 32'(o1_sync), 0);
        send1(2'd0, 24'h000020); chk("mrst sync c2", 32'(o1_sync), 0);
        send1(2'd0, 24'hFFFFF0); chk("mrst sync c3", 32'(o1_sync), 0);
        send1(2'd0, 24'h000005);
        chk("mrst sync c4", 32'(o1_sync), 0);
        chk("mrst dv", 32'(o1_dv), 1);
        chk("mrst ch", 32'(o1_ch), 0);
        chk("mrst d",  32'(o1_d),  32'h00000020);
        tick();
        chk("mrst sync c5", 32'(o1_sync), 1);
        chk("mrst dv drop", 32'(o1_dv), 0);
        tick();
        chk("mrst sync c6", 32'(o1_sync), 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
